usr_access_arbiter: RTL and testbench

USR_ACCESS_ARBITER -- requirements
Module: usr_access_arbiter

---
 rtl/usr_access_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_usr_access_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_access_arbiter.sv
// ---------------------------------------------------------------------------
// usr_access_arbiter
//
// Captures a quasi-static, asynchronous 32-bit USR_ACCESS word once it has
// been seen unchanged for STABLE_CNT consecutive cycles after the
// (synchronized) valid flag is high. It then serves that word to NUM_REQ
// requesters through a round-robin arbiter that grants one single-cycle
// acknowledge at a time. If no word is captured within TIMEOUT cycles the
// block enters FAULT, where requesters are still acknowledged but receive
// zero data.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   STABLE_CNT   identical consecutive samples needed to accept a word (1..15)
//   TIMEOUT      cycles tolerated in WAIT_VALID/SAMPLE before FAULT (1..65535)
//
// Ports
//   CLK            clock, all logic on the rising edge
//   RST            synchronous active-high reset
//   DATAVALID_IN   asynchronous valid flag (2-flop synchronized internally)
//   DATA_IN        asynchronous quasi-static data word
//   RESAMPLE       single-cycle pulse: drop the captured word, restart capture
//   REQ            per-requester read-request levels
//   ACK            per-requester single-cycle acknowledges (registered)
//   RDATA          returned word, non-zero only while an ACK bit is high
//   VALID          high while a captured word is held (READY)
//   ERR            high while in FAULT
// ---------------------------------------------------------------------------
module usr_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               DATAVALID_IN,
    input  logic [31:0]        DATA_IN,
    input  logic               RESAMPLE,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] ACK,
    output logic [31:0]        RDATA,
    output logic               VALID,
    output logic               ERR
);

    localparam int          PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]  STABLE_C = 4'(STABLE_CNT);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_WAIT_VALID = 2'd0,
        S_SAMPLE     = 2'd1,
        S_READY      = 2'd2,
        S_FAULT      = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Capture side state
    // -----------------------------------------------------------------------
    state_t       state_q;
    logic         dv_meta_q;
    logic         dv_s_q;
    logic [3:0]   cnt_q;
    logic [15:0]  tcnt_q;
    logic [31:0]  last_q;
    logic [31:0]  word_q;
    logic         valid_q;
    logic         err_q;

    // -----------------------------------------------------------------------
    // Arbiter state
    // -----------------------------------------------------------------------
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] ack_d;
    logic [31:0]        rdata_q;
    logic [31:0]        rdata_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;

    logic [3:0]  cnt_inc;
    logic [15:0] tcnt_inc;
    logic        timeout_hit;
    logic        stable_hit;

    // A new sample extends the run when it is the first one of a run or it
    // matches the previous sample; any change restarts the run at 1.
    assign cnt_inc     = (cnt_q == 4'd0 || DATA_IN == last_q) ? (cnt_q + 4'd1) : 4'd1;
    assign stable_hit  = (cnt_inc == STABLE_C);
    assign tcnt_inc    = tcnt_q + 16'd1;
    assign timeout_hit = (tcnt_inc == TIMEOUT_C);

    // -----------------------------------------------------------------------
    // Synchronizer + capture FSM (single registered process)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_WAIT_VALID;
            dv_meta_q <= 1'b0;
            dv_s_q    <= 1'b0;
            cnt_q     <= 4'd0;
            tcnt_q    <= 16'd0;
            last_q    <= 32'd0;
            word_q    <= 32'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dv_meta_q <= DATAVALID_IN;
            dv_s_q    <= dv_meta_q;

            if (RESAMPLE) begin
                // Restart from any state; the word itself is left in place
                // but is no longer advertised.
                state_q <= S_WAIT_VALID;
                cnt_q   <= 4'd0;
                tcnt_q  <= 16'd0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_WAIT_VALID: begin
                        tcnt_q <= tcnt_inc;
                        if (timeout_hit) begin
                            state_q <= S_FAULT;
                            err_q   <= 1'b1;
                        end else if (dv_s_q) begin
                            state_q <= S_SAMPLE;
                            cnt_q   <= 4'd0;
                        end
                    end

                    S_SAMPLE: begin
                        tcnt_q <= tcnt_inc;
                        if (timeout_hit) begin
                            // Timeout wins over a capture in the same cycle.
                            state_q <= S_FAULT;
                            err_q   <= 1'b1;
                            cnt_q   <= 4'd0;
                        end else if (!dv_s_q) begin
                            state_q <= S_WAIT_VALID;
                            cnt_q   <= 4'd0;
                        end else begin
                            last_q <= DATA_IN;
                            cnt_q  <= cnt_inc;
                            if (stable_hit) begin
                                word_q  <= DATA_IN;
                                state_q <= S_READY;
                                valid_q <= 1'b1;
                                tcnt_q  <= 16'd0;
                            end
                        end
                    end

                    S_READY: begin
                        // Held until RESAMPLE or RST; dv_s is ignored here.
                    end

                    S_FAULT: begin
                        // Held until RESAMPLE or RST.
                    end

                    default: begin
                        state_q <= S_WAIT_VALID;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin grant selection
    //
    // Only one acknowledge is outstanding at a time: no grant is made in a
    // cycle where an ACK is already high, so a requester holding REQ through
    // its ACK is not re-granted back to back and competing requesters are
    // served on alternate cycles. The grant decision uses the current state,
    // so a grant made in the same cycle as RESAMPLE still completes.
    // -----------------------------------------------------------------------
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        ack_d   = '0;
        rdata_d = 32'd0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        if ((state_q == S_READY || state_q == S_FAULT) && (ack_q == '0)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
                if (!found && REQ[idx] && !ack_q[idx]) begin
                    found      = 1'b1;
                    ack_d[idx] = 1'b1;
                    ptr_d      = (idx == LAST_IDX) ? '0 : (idx + 1'b1);
                    rdata_d    = (state_q == S_READY) ? word_q : 32'd0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_q   <= '0;
            rdata_q <= 32'd0;
            ptr_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ACK   = ack_q;
    assign RDATA = rdata_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_usr_access_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for usr_access_arbiter.
// u_dut : NUM_REQ=4, STABLE_CNT=3, TIMEOUT=1023 (capture, arbitration)
// u_to  : NUM_REQ=4, STABLE_CNT=3, TIMEOUT=16   (timeout / FAULT behaviour)
// ---------------------------------------------------------------------------
module tb_usr_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;

    // u_dut signals
    logic        dv;
    logic [31:0] data;
    logic        resample;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [31:0] rdata;
    logic        valid;
    logic        err;

    // u_to signals
    logic        dv2;
    logic [31:0] data2;
    logic        resample2;
    logic [3:0]  req2;
    logic [3:0]  ack2;
    logic [31:0] rdata2;
    logic        valid2;
    logic        err2;

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] rdata;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    sb_t  exp_q[$];
    sb_t  e;
    vec_t vecs[22];
    logic [31:0] pat[11];

    usr_access_arbiter #(.NUM_REQ(4), .STABLE_CNT(3), .TIMEOUT(1023)) u_dut (
        .CLK(clk), .RST(rst), .DATAVALID_IN(dv), .DATA_IN(data),
        .RESAMPLE(resample), .REQ(req), .ACK(ack), .RDATA(rdata),
        .VALID(valid), .ERR(err)
    );

    usr_access_arbiter #(.NUM_REQ(4), .STABLE_CNT(3), .TIMEOUT(16)) u_to (
        .CLK(clk), .RST(rst), .DATAVALID_IN(dv2), .DATA_IN(data2),
        .RESAMPLE(resample2), .REQ(req2), .ACK(ack2), .RDATA(rdata2),
        .VALID(valid2), .ERR(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every ACK must match the next expected grant (bits, data
    // and cycle); idle cycles must have RDATA=0 and no overdue grant.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack !== 4'b0000) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_ack: got ack=%b rdata=%h at cycle %0d, required none",
                             ack, rdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (ack !== e.ack || rdata !== e.rdata || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL sb_ack: got ack=%b rdata=%h cycle=%0d required ack=%b rdata=%h cycle=%0d",
                                 ack, rdata, cyc, e.ack, e.rdata, e.cyc);
                    end
                end
            end else begin
                n_tests++;
                if (rdata !== 32'd0) begin
                    n_fail++;
                    $display("FAIL rdata_idle: got %h required 0 (cycle %0d)", rdata, cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_missing_ack: got ack=0000 required ack=%b at cycle %0d",
                             e.ack, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish within 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arbitration vectors: req applied for one cycle, ack expected after
        // that cycle's edge. Word held is 32'hCAFE_0001, ptr starts at 0.
        vecs[0]  = '{4'b1111, 4'b0001, 32'hCAFE_0001};
        vecs[1]  = '{4'b1111, 4'b0000, 32'h0};
        vecs[2]  = '{4'b1111, 4'b0010, 32'hCAFE_0001};
        vecs[3]  = '{4'b1111, 4'b0000, 32'h0};
        vecs[4]  = '{4'b1111, 4'b0100, 32'hCAFE_0001};
        vecs[5]  = '{4'b1111, 4'b0000, 32'h0};
        vecs[6]  = '{4'b1111, 4'b1000, 32'hCAFE_0001};
        vecs[7]  = '{4'b1111, 4'b0000, 32'h0};
        vecs[8]  = '{4'b1111, 4'b0001, 32'hCAFE_0001};
        vecs[9]  = '{4'b0000, 4'b0000, 32'h0};
        vecs[10] = '{4'b0100, 4'b0100, 32'hCAFE_0001};
        vecs[11] = '{4'b0000, 4'b0000, 32'h0};
        vecs[12] = '{4'b1001, 4'b1000, 32'hCAFE_0001};
        vecs[13] = '{4'b0001, 4'b0000, 32'h0};
        vecs[14] = '{4'b0001, 4'b0001, 32'hCAFE_0001};
        vecs[15] = '{4'b0000, 4'b0000, 32'h0};
        vecs[16] = '{4'b0010, 4'b0010, 32'hCAFE_0001};
        vecs[17] = '{4'b0000, 4'b0000, 32'h0};
        vecs[18] = '{4'b0011, 4'b0001, 32'hCAFE_0001};
        vecs[19] = '{4'b0010, 4'b0000, 32'h0};
        vecs[20] = '{4'b0010, 4'b0010, 32'hCAFE_0001};
        vecs[21] = '{4'b0000, 4'b0000, 32'h0};

        // Glitch data per edge offset after RESAMPLE: alternate 1/2 for five
        // samples (offsets 3..7), then settle on 2.
        pat[0] = 32'h1; pat[1] = 32'h1; pat[2]  = 32'h1; pat[3] = 32'h1;
        pat[4] = 32'h2; pat[5] = 32'h1; pat[6]  = 32'h2; pat[7] = 32'h1;
        pat[8] = 32'h2; pat[9] = 32'h2; pat[10] = 32'h2;

        // Reset, with RESAMPLE and REQ active to show RST overrides them.
        rst = 1'b1; dv = 1'b0; data = 32'h0; resample = 1'b1; req = 4'b1111;
        dv2 = 1'b0; data2 = 32'h0; resample2 = 1'b1; req2 = 4'b1111;
        step(); step(); step();
        chk("rst_ack",    32'(ack),    32'h0);
        chk("rst_rdata",  rdata,       32'h0);
        chk("rst_valid",  32'(valid),  32'h0);
        chk("rst_err",    32'(err),    32'h0);
        chk("rst_ack2",   32'(ack2),   32'h0);
        chk("rst_err2",   32'(err2),   32'h0);
        rst = 1'b0; resample = 1'b0; req = 4'b0000;
        resample2 = 1'b0; req2 = 4'b0000;
        mon_en = 1'b1;

        // Timeout: no valid flag, ERR after 16 cycles.
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("to_err_k%0d", k), 32'(err2), (k >= 16) ? 32'h1 : 32'h0);
        end
        req2 = 4'b0010;
        step();
        chk("fault_ack", 32'(ack2), 32'h2);
        chk("fault_rdata", rdata2, 32'h0);
        req2 = 4'b0000;
        step();
        chk("fault_ack_clr", 32'(ack2), 32'h0);
        resample2 = 1'b1;
        step();
        resample2 = 1'b0;
        chk("fault_resample_err", 32'(err2), 32'h0);
        chk("fault_resample_valid", 32'(valid2), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("to2_err_k%0d", k), 32'(err2), (k == 16) ? 32'h1 : 32'h0);
        end

        // Capture: VALID rises on the 6th edge that sees DATAVALID_IN high.
        dv = 1'b1; data = 32'hCAFE_0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("cap_valid_e%0d", k), 32'(valid), (k == 6) ? 32'h1 : 32'h0);
        end

        // Round-robin and arbitration vectors.
        for (int i = 0; i < 22; i++) begin
            req = vecs[i].req;
            if (vecs[i].exp_ack != 4'b0000)
                exp_q.push_back('{vecs[i].exp_ack, vecs[i].exp_rdata, cyc + 1});
            step();
        end
        step();

        // Glitch: alternating data, then settle on 32'h2.
        resample = 1'b1; data = 32'h1;
        step();
        resample = 1'b0;
        chk("glitch_valid_clr", 32'(valid), 32'h0);
        for (int k = 2; k <= 10; k++) begin
            data = pat[k];
            step();
            chk($sformatf("glitch_valid_k%0d", k), 32'(valid), (k == 10) ? 32'h1 : 32'h0);
        end
        req = 4'b0010;
        exp_q.push_back('{4'b0010, 32'h2, cyc + 1});
        step();
        req = 4'b0000;
        step(); step();

        // Grant in the RESAMPLE cycle completes; REQ[0] then waits for recapture.
        resample = 1'b1; req = 4'b0010; data = 32'h3;
        exp_q.push_back('{4'b0010, 32'h2, cyc + 1});
        step();
        resample = 1'b0; req = 4'b0001;
        chk("rs_valid_clr", 32'(valid), 32'h0);
        exp_q.push_back('{4'b0001, 32'h3, cyc + 5});
        for (int k = 2; k <= 6; k++) begin
            step();
            chk($sformatf("rs_valid_k%0d", k), 32'(valid), (k >= 5) ? 32'h1 : 32'h0);
        end
        req = 4'b0000;
        step(); step();

        // RST in the middle of SAMPLE.
        resample = 1'b1;
        step();
        resample = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_ack",   32'(ack),   32'h0);
        chk("rstmid_rdata", rdata,      32'h0);
        chk("rstmid_valid", 32'(valid), 32'h0);
        chk("rstmid_err",   32'(err),   32'h0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("recap_valid_e%0d", k), 32'(valid), (k == 6) ? 32'h1 : 32'h0);
        end
        // Pointer is back at 0, so requester 0 beats requester 3.
        req = 4'b1001;
        exp_q.push_back('{4'b0001, 32'h3, cyc + 1});
        step();
        req = 4'b0000;
        step(); step();

        // RST wins over a same-cycle request in READY.
        req = 4'b0010; rst = 1'b1;
        step();
        req = 4'b0000; rst = 1'b0;
        chk("rst_ovr_ack",   32'(ack),   32'h0);
        chk("rst_ovr_valid", 32'(valid), 32'h0);
        step(); step();

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
